// File: rtl/picorv32_pcpi_pkg.sv
// Shared PCPI definitions: issue FSM states and RV32M decode constants used by the
// issue unit, the coprocessors and the benches.
package picorv32_pcpi_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StResp
  } pcpi_state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  localparam logic [2:0] F3_MUL     = 3'b000;
  localparam logic [2:0] F3_MULH    = 3'b001;
  localparam logic [2:0] F3_MULHSU  = 3'b010;
  localparam logic [2:0] F3_MULHU   = 3'b011;
  localparam logic [2:0] F3_DIV     = 3'b100;
  localparam logic [2:0] F3_DIVU    = 3'b101;
  localparam logic [2:0] F3_REM     = 3'b110;
  localparam logic [2:0] F3_REMU    = 3'b111;

  localparam int unsigned TMO_W = 8;

  function automatic logic is_muldiv(input logic [31:0] insn);
    return (insn[6:0] == OPC_OP) && (insn[31:25] == F7_MULDIV);
  endfunction

  // funct3[2] splits the M extension into multiply (0) and divide/remainder (1)
  function automatic logic is_divrem(input logic [31:0] insn);
    return is_muldiv(insn) && insn[14];
  endfunction

endpackage

// File: rtl/picorv32_pcpi_timeout.sv
// Loadable down-counter for the no-responder timeout; load has priority over
// decrement so a pcpi_wait reload is never lost.
module picorv32_pcpi_timeout #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [Width-1:0] r_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - Width'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/picorv32_pcpi_issue.sv
// CPU-side PCPI initiator: takes one instruction on a valid/ready port, drives it
// to a responder, applies the no-responder timeout and returns the result or a trap.
module picorv32_pcpi_issue
  import picorv32_pcpi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned LAT_W          = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_insn,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_wr,
  output logic [31:0]      rsp_rd,
  output logic             rsp_trap,
  output logic [LAT_W-1:0] rsp_cycles,
  output logic             pcpi_valid,
  output logic [31:0]      pcpi_insn,
  output logic [31:0]      pcpi_rs1,
  output logic [31:0]      pcpi_rs2,
  input  logic             pcpi_wr,
  input  logic [31:0]      pcpi_rd,
  input  logic             pcpi_wait,
  input  logic             pcpi_ready
);

  localparam logic [TMO_W-1:0] TmoInit = TMO_W'(TIMEOUT_CYCLES - 1);

  pcpi_state_e r_state, w_state_nxt;

  logic             w_accept, w_done, w_trap;
  logic             w_tmo_load, w_tmo_dec, w_tmo_zero;
  logic             r_pcpi_valid;
  logic [31:0]      r_insn, r_rs1, r_rs2;
  logic             r_rsp_valid, r_rsp_wr, r_rsp_trap;
  logic [31:0]      r_rsp_rd;
  logic [LAT_W-1:0] r_cycles;

  // Held low through reset so nothing is accepted before the FSM is live.
  assign req_ready = (r_state == StIdle) && resetn;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_trap      = 1'b0;
    w_tmo_load  = 1'b0;
    w_tmo_dec   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (req_valid && req_ready) begin
          w_accept    = 1'b1;
          w_tmo_load  = 1'b1;
          w_state_nxt = StIssue;
        end
      end
      StIssue: begin
        // ready outranks an expiring timeout in the same cycle
        if (pcpi_ready) begin
          w_done      = 1'b1;
          w_state_nxt = StResp;
        end else if (pcpi_wait) begin
          w_tmo_load  = 1'b1;
        end else if (w_tmo_zero) begin
          w_trap      = 1'b1;
          w_state_nxt = StResp;
        end else begin
          w_tmo_dec   = 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  picorv32_pcpi_timeout #(
    .Width(TMO_W)
  ) u_timeout (
    .clk       (clk),
    .resetn    (resetn),
    .i_load    (w_tmo_load),
    .i_load_val(TmoInit),
    .i_dec     (w_tmo_dec),
    .o_zero    (w_tmo_zero)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pcpi_valid <= 1'b0;
      r_insn       <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_wr     <= 1'b0;
      r_rsp_rd     <= '0;
      r_rsp_trap   <= 1'b0;
      r_cycles     <= '0;
    end else begin
      if (w_accept) begin
        r_insn       <= req_insn;
        r_rs1        <= req_rs1;
        r_rs2        <= req_rs2;
        r_pcpi_valid <= 1'b1;
        r_cycles     <= '0;
      end
      if ((r_state == StIssue) && (r_cycles != '1)) begin
        r_cycles <= r_cycles + LAT_W'(1);
      end
      if (w_done) begin
        r_pcpi_valid <= 1'b0;
        r_rsp_valid  <= 1'b1;
        r_rsp_rd     <= pcpi_rd;
        r_rsp_wr     <= pcpi_wr;
        r_rsp_trap   <= 1'b0;
      end
      if (w_trap) begin
        r_pcpi_valid <= 1'b0;
        r_rsp_valid  <= 1'b1;
        r_rsp_rd     <= '0;
        r_rsp_wr     <= 1'b0;
        r_rsp_trap   <= 1'b1;
      end
      if ((r_state == StResp) && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign pcpi_valid = r_pcpi_valid;
  assign pcpi_insn  = r_insn;
  assign pcpi_rs1   = r_rs1;
  assign pcpi_rs2   = r_rs2;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_wr     = r_rsp_wr;
  assign rsp_rd     = r_rsp_rd;
  assign rsp_trap   = r_rsp_trap;
  assign rsp_cycles = r_cycles;

endmodule
